// File: rtl/ma216_audio_pkg.sv
// ----------------------------------------------------------------------------
// ma216_audio_pkg
// Shared constants and helpers for the MA216 sound board audio output stage.
//   - sample/DAC/volume widths and the unity-gain volume code
//   - 16-bit saturation limits
//   - dac_to_signed : offset-binary DAC byte -> signed 16-bit sample
//   - sat_s16       : clamp a wide signed value into the 16-bit sample range
// No ports (package).
// ----------------------------------------------------------------------------
package ma216_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DAC_W      = 8;
  localparam int VOL_W      = 5;
  localparam int VOL_UNITY  = 16;
  // vol/16 gain is implemented as (y * vol) >>> GAIN_SHIFT
  localparam int GAIN_SHIFT = $clog2(VOL_UNITY);
  // signed 16-bit sample times unsigned 5-bit volume (sign bit added)
  localparam int PROD_W     = SAMPLE_W + VOL_W + 1;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  // The DAC byte is offset binary: 0x80 is mid-scale. Flipping the MSB gives
  // two's complement; the byte is placed in the top of the 16-bit word.
  function automatic logic signed [SAMPLE_W-1:0] dac_to_signed(input logic [DAC_W-1:0] d);
    return {~d[DAC_W-1], d[DAC_W-2:0], {(SAMPLE_W-DAC_W){1'b0}}};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_s16(input logic signed [23:0] v);
    if (v > 24'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (v < 24'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return SAMPLE_W'(v);
    end
  endfunction

endpackage

// File: rtl/ma216_lpf.sv
// ----------------------------------------------------------------------------
// ma216_lpf
// One-pole shift low-pass: acc <= acc + x - (acc >>> SHIFT), y = acc >>> SHIFT.
// The accumulator carries SHIFT extra bits so it holds x * 2^SHIFT at steady
// state without overflow. SHIFT = 0 degenerates to y = x (bypass).
// y is taken from the registered accumulator, so it reflects the new input
// one cycle after an enabled update.
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low reset (clears the accumulator)
//   en      in   update enable (one pulse per sample)
//   x       in   signed W-bit input
//   y       out  signed W-bit filtered output
// ----------------------------------------------------------------------------
module ma216_lpf
  import ma216_audio_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int SHIFT = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  localparam int AW = W + SHIFT;

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] acc_shr;
  logic signed [AW:0]   sum;

  always_comb begin
    acc_shr = acc_q >>> SHIFT;
    // one guard bit for the intermediate; the settled result always fits AW
    sum     = (AW+1)'(acc_q) + (AW+1)'(x) - (AW+1)'(acc_shr);
    acc_d   = AW'(sum);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign y = W'(acc_shr);

endmodule

// File: rtl/ma216_audio_out.sv
// ----------------------------------------------------------------------------
// ma216_audio_out
// Output stage behind the MA216 8-bit DAC latch. Resamples the DAC byte every
// SAMPLE_DIV clocks, converts to signed 16-bit, low-passes it like the board's
// RC filter, applies a vol/16 gain with saturation and strobes the result.
//
// Pipeline (each stage advances only on its own valid flag, started by tick):
//   S1  x  = mute ? 0 : dac_to_signed(dac)
//   S2  y  = one-pole low-pass of x (alpha = 2^-FILT_SHIFT)
//   S2b d  = sat(y - dc_estimate)      (only with MA216_DCBLOCK_EN)
//   S3  p  = y (or d) * vol
//   S4  sample = sat(p >>> 4), sample_valid for one cycle
// Latency tick -> sample_valid is 4 clocks (5 with MA216_DCBLOCK_EN).
//
// Optional feature macro: MA216_DCBLOCK_EN (adds the DC-blocking stage S2b,
// using DC_SHIFT; when undefined DC_SHIFT has no effect).
//
// Ports:
//   clk          in   board clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   dac[7:0]     in   unsigned DAC byte from the sound board latch
//   mute         in   forces the filter target to 0
//   vol[4:0]     in   gain = vol/16
//   sample[15:0] out  signed output sample, held between strobes
//   sample_valid out  one-cycle strobe when sample updates
// ----------------------------------------------------------------------------
module ma216_audio_out
  import ma216_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 75,
  parameter int FILT_SHIFT = 3,
  parameter int DC_SHIFT   = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic        [DAC_W-1:0]    dac,
  input  logic                       mute,
  input  logic        [VOL_W-1:0]    vol,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  localparam int CNT_W = 16;

  if (SAMPLE_DIV < 2 || SAMPLE_DIV > 65535 || FILT_SHIFT < 0 || DC_SHIFT < 1) begin : g_bad_param
    $error("ma216_audio_out: parameter out of range");
  end

  // --------------------------------------------------------------------------
  // Sample-rate tick
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick;

  always_comb begin
    tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // S1: capture and convert
  // --------------------------------------------------------------------------
  logic signed [SAMPLE_W-1:0] x_q;
  logic                       v1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= tick;
      if (tick) begin
        x_q <= mute ? '0 : dac_to_signed(dac);
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: RC-emulating low-pass
  // --------------------------------------------------------------------------
  logic signed [SAMPLE_W-1:0] y;
  logic                       v2_q;

  ma216_lpf #(
    .W     (SAMPLE_W),
    .SHIFT (FILT_SHIFT)
  ) u_lpf (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (v1_q),
    .x       (x_q),
    .y       (y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
    end
  end

  // --------------------------------------------------------------------------
  // S2b (optional): DC block. The estimator is a slow low-pass of y; its
  // pre-update value is subtracted so a constant input settles to exactly 0.
  // --------------------------------------------------------------------------
  logic signed [SAMPLE_W-1:0] s3_in;
  logic                       s3_v;

`ifdef MA216_DCBLOCK_EN
  logic signed [SAMPLE_W-1:0] dc_y;
  logic signed [SAMPLE_W-1:0] d_q;
  logic                       v2b_q;

  ma216_lpf #(
    .W     (SAMPLE_W),
    .SHIFT (DC_SHIFT)
  ) u_dc_est (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (v2_q),
    .x       (y),
    .y       (dc_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q   <= '0;
      v2b_q <= 1'b0;
    end else begin
      v2b_q <= v2_q;
      if (v2_q) begin
        d_q <= sat_s16(24'(17'(y) - 17'(dc_y)));
      end
    end
  end

  assign s3_in = d_q;
  assign s3_v  = v2b_q;
`else
  assign s3_in = y;
  assign s3_v  = v2_q;
`endif

  // --------------------------------------------------------------------------
  // S3: gain multiply
  // --------------------------------------------------------------------------
  logic signed [PROD_W-1:0] p_q;
  logic signed [PROD_W-1:0] prod;
  logic                     v3_q;

  // vol is unsigned; a zero sign bit keeps the multiply signed throughout
  assign prod = PROD_W'(s3_in) * PROD_W'($signed({1'b0, vol}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      v3_q <= s3_v;
      if (s3_v) begin
        p_q <= prod;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S4: scale by 1/16 (floor), saturate, register output
  // --------------------------------------------------------------------------
  logic signed [PROD_W-1:0]   g;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic                       valid_q;

  assign g = p_q >>> GAIN_SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= v3_q;
      if (v3_q) begin
        sample_q <= sat_s16(24'(g));
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_ma216_audio_out.sv
// ----------------------------------------------------------------------------
// tb_ma216_audio_out
// Directed bench for ma216_audio_out. Two instances share the inputs:
//   dut      : default parameters (SAMPLE_DIV=75, FILT_SHIFT=3)
//   dut_byp  : SAMPLE_DIV=2, FILT_SHIFT=0 (filter bypass, fast sample rate)
// With MA216_DCBLOCK_EN defined the latency and DC-block checks replace the
// filter/gain value checks.
// ----------------------------------------------------------------------------
module tb_ma216_audio_out;

`ifdef MA216_DCBLOCK_EN
  localparam int FIRST_LAT = 79;
`else
  localparam int FIRST_LAT = 78;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic        [7:0]  dac;
  logic               mute;
  logic        [4:0]  vol;
  logic signed [15:0] sample_def;
  logic signed [15:0] sample_byp;
  logic               sv_def;
  logic               sv_byp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ma216_audio_out dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dac          (dac),
    .mute         (mute),
    .vol          (vol),
    .sample       (sample_def),
    .sample_valid (sv_def)
  );

  ma216_audio_out #(
    .SAMPLE_DIV (2),
    .FILT_SHIFT (0)
  ) dut_byp (
    .clk          (clk),
    .reset_n      (reset_n),
    .dac          (dac),
    .mute         (mute),
    .vol          (vol),
    .sample       (sample_byp),
    .sample_valid (sv_byp)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Waits for the next strobe of instance 'which' (0 = dut, 1 = dut_byp);
  // n = clock edges consumed. An expired budget counts as a failure.
  task automatic wait_strobe(input int which, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      n++;
      if ((which == 0 && sv_def) || (which == 1 && sv_byp)) return;
    end
    check("strobe_timeout", 0, 1);
    n = -1;
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] v;
    logic       m;
    int         e;
  } vec_t;

  vec_t vecs [10] = '{
    '{8'hFF, 5'd16, 1'b0,  32512},
    '{8'h80, 5'd16, 1'b0,      0},
    '{8'h00, 5'd16, 1'b0, -32768},
    '{8'hFF, 5'd31, 1'b0,  32767},
    '{8'h00, 5'd31, 1'b0, -32768},
    '{8'hC0, 5'd8,  1'b0,   8192},
    '{8'hFF, 5'd0,  1'b0,      0},
    '{8'h00, 5'd0,  1'b0,      0},
    '{8'h81, 5'd1,  1'b0,     16},
    '{8'hFF, 5'd16, 1'b1,      0}
  };

  initial begin
    int n;
    int prev;
    int cur;

    reset_n = 1'b0;
    dac     = 8'h80;
    mute    = 1'b0;
    vol     = 5'd16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", int'(sample_def), 0);
    check("rst_valid", int'(sv_def), 0);
    check("rst_byp_sample", int'(sample_byp), 0);

    // tick timing
    @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(0, 200, n);
    check("first_strobe_latency", n, FIRST_LAT);
    wait_strobe(0, 200, n);
    check("strobe_period", n, 75);
    @(posedge clk);
    #1;
    check("pulse_width", int'(sv_def), 0);

`ifndef MA216_DCBLOCK_EN
    // low-pass step from settled mid-scale to full scale
    dac = 8'hFF;
    wait_strobe(0, 200, n);
    check("lp_step_1", int'(sample_def), 4064);
    repeat (10) @(posedge clk);
    #1;
    check("hold_value", int'(sample_def), 4064);
    check("hold_no_strobe", int'(sv_def), 0);
    wait_strobe(0, 200, n);
    check("lp_step_2", int'(sample_def), 7620);
    prev = int'(sample_def);
    for (int i = 3; i <= 150; i++) begin
      wait_strobe(0, 200, n);
      cur = int'(sample_def);
      check($sformatf("lp_rise_%0d", i), int'(cur >= prev), 1);
      prev = cur;
    end
    cur = int'(sample_def) - 32512;
    if (cur < 0) cur = -cur;
    check("lp_settle_within_1", int'(cur <= 1), 1);

    // mute: exponential decay, no step
    mute = 1'b1;
    wait_strobe(0, 200, n);
    check("mute_1", int'(sample_def), 28448);
    wait_strobe(0, 200, n);
    check("mute_2", int'(sample_def), 24892);
    prev = int'(sample_def);
    for (int i = 3; i <= 6; i++) begin
      wait_strobe(0, 200, n);
      cur = int'(sample_def);
      check($sformatf("mute_decay_%0d", i), int'(cur < prev && cur > 0), 1);
      prev = cur;
    end
`endif

    // asynchronous reset mid-period
    repeat (20) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_sample", int'(sample_def), 0);
    check("async_rst_valid", int'(sv_def), 0);
    mute = 1'b0;
    dac  = 8'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(0, 200, n);
    check("post_rst_latency", n, FIRST_LAT);
    check("post_rst_filter_cleared", int'(sample_def), 0);

`ifndef MA216_DCBLOCK_EN
    // conversion, gain and saturation on the bypass instance
    for (int i = 0; i < 10; i++) begin
      dac  = vecs[i].d;
      vol  = vecs[i].v;
      mute = vecs[i].m;
      // let samples already in flight drain
      for (int k = 0; k < 4; k++) wait_strobe(1, 20, n);
      check($sformatf("byp_d%02h_v%0d_m%0d", vecs[i].d, vecs[i].v, vecs[i].m),
            int'(sample_byp), int'($signed(vecs[i].e)));
    end
`else
    // DC block: a constant full-scale input settles to ~0
    dac  = 8'hFF;
    vol  = 5'd16;
    mute = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      wait_strobe(1, 20, n);
      if (n < 0) break;
    end
    cur = int'(sample_byp);
    if (cur < 0) cur = -cur;
    check("dcblock_converged", int'(cur < 64), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
